impulse_mac: RTL and testbench

//  Convolution multiply-accumulate stage directly downstream of the memory controller.

---
 rtl/impulse_mac.sv | 143 ++++++++++++++
 tb/tb_impulse_mac.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/impulse_mac.sv
// Convolution MAC stage: accumulates sample x impulse-coefficient tap pairs on top of
// the dry sample once per ADC frame and emits one saturated 16-bit wet sample.
module impulse_mac #(
    parameter int MAX_TAPS    = 255,
    parameter int FRAC_SHIFT  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adc_clock,
    input  logic [15:0] dry_in,
    input  logic        tap_valid,
    output logic        tap_ready,
    input  logic        tap_last,
    input  logic [15:0] impulse_word,
    input  logic [15:0] sample_word,
    output logic [15:0] data_out,
    output logic        out_valid,
    output logic        busy,
    output logic        sat_flag,
    output logic        overrun_flag
);

    localparam int CNT_W = $clog2(MAX_TAPS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        CLIP  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                   state;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     sync_d;
    logic                     start;
    logic                     pending;
    logic signed [31:0]       acc;
    logic [CNT_W-1:0]         tap_cnt;
    logic [CNT_W-1:0]         tap_cnt_inc;

    logic signed [24:0]       prod;
    logic signed [31:0]       prod_ext;
    logic signed [31:0]       term;
    logic signed [31:0]       dry_scaled;
    logic signed [31:0]       shifted;
    logic [15:0]              clipped;
    logic                     clip_hit;
    logic                     unused_offsets;

    // Offset fields are consumed by the memory controller, not by this stage.
    assign unused_offsets = ^impulse_word[15:9];

    assign start       = sync_q[SYNC_STAGES-1] & ~sync_d;
    assign tap_ready   = (state == ACCUM);
    assign busy        = (state != IDLE);
    assign tap_cnt_inc = tap_cnt + 1'b1;

    assign prod       = $signed(sample_word) * $signed({1'b0, impulse_word[7:0]});
    assign prod_ext   = {{7{prod[24]}}, prod};
    assign term       = impulse_word[8] ? -prod_ext : prod_ext;
    assign dry_scaled = $signed({{16{dry_in[15]}}, dry_in}) <<< FRAC_SHIFT;
    assign shifted    = acc >>> FRAC_SHIFT;

    // NOTE: every output of a combinational block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        clipped  = shifted[15:0];
        clip_hit = 1'b0;
        if (shifted > 32'sd32767) begin
            clipped  = 16'h7FFF;
            clip_hit = 1'b1;
        end else if (shifted < -32'sd32768) begin
            clipped  = 16'h8000;
            clip_hit = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sync_q       <= '0;
            sync_d       <= 1'b0;
            pending      <= 1'b0;
            acc          <= '0;
            tap_cnt      <= '0;
            data_out     <= '0;
            out_valid    <= 1'b0;
            sat_flag     <= 1'b0;
            overrun_flag <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], adc_clock};
            sync_d    <= sync_q[SYNC_STAGES-1];
            out_valid <= 1'b0;

            // Frame edges arriving while a frame is in flight queue one frame deep.
            if (start && state != IDLE) begin
                pending <= 1'b1;
                if (pending) overrun_flag <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start || pending) begin
                        acc     <= dry_scaled;
                        tap_cnt <= '0;
                        pending <= pending & start;
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (tap_valid) begin
                        acc     <= acc + term;
                        tap_cnt <= tap_cnt_inc;
                        if (tap_last) begin
                            state <= CLIP;
                        end else if (tap_cnt_inc == CNT_W'(MAX_TAPS)) begin
                            state        <= CLIP;
                            overrun_flag <= 1'b1;
                        end
                    end
                    if (start) begin
                        overrun_flag <= 1'b1;
                        state        <= CLIP;
                    end
                end
                CLIP: begin
                    data_out  <= clipped;
                    out_valid <= 1'b1;
                    if (clip_hit) sat_flag <= 1'b1;
                    state <= OUT;
                end
                OUT: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_impulse_mac.sv
// Directed self-checking bench for impulse_mac: latency, sign, saturation, early
// frame edge, MAX_TAPS limit, mid-frame reset and zero-tap frame.
module tb_impulse_mac;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        adc_clock;
    logic [15:0] dry_in;
    logic        tap_valid;
    logic        tap_ready;
    logic        tap_last;
    logic [15:0] impulse_word;
    logic [15:0] sample_word;
    logic [15:0] data_out;
    logic        out_valid;
    logic        busy;
    logic        sat_flag;
    logic        overrun_flag;

    int checks = 0;
    int errors = 0;

    impulse_mac #(.MAX_TAPS(255), .FRAC_SHIFT(8), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .adc_clock    (adc_clock),
        .dry_in       (dry_in),
        .tap_valid    (tap_valid),
        .tap_ready    (tap_ready),
        .tap_last     (tap_last),
        .impulse_word (impulse_word),
        .sample_word  (sample_word),
        .data_out     (data_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .sat_flag     (sat_flag),
        .overrun_flag (overrun_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [15:0] dry);
        int n = 0;
        dry_in    = dry;
        adc_clock = 1'b1;
        while (!tap_ready && n < 10) begin
            tick();
            n++;
        end
        check("frame_start", {31'd0, tap_ready}, 32'd1);
        adc_clock = 1'b0;
    endtask

    task automatic send_tap(input logic [15:0] sample, input logic neg,
                            input logic [7:0] mult, input logic last);
        int   n   = 0;
        logic got = 1'b0;
        sample_word  = sample;
        impulse_word = {7'd0, neg, mult};
        tap_last     = last;
        tap_valid    = 1'b1;
        while (!got && n < 20) begin
            got = tap_ready;
            tick();
            n++;
        end
        tap_valid = 1'b0;
        tap_last  = 1'b0;
        check("tap_accept", {31'd0, got}, 32'd1);
    endtask

    task automatic wait_out(output logic [15:0] d);
        int n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check("out_valid_seen", {31'd0, out_valid}, 32'd1);
        d = data_out;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    logic [15:0] d;
    int          accepted;
    logic        seen;
    logic [15:0] seen_data;
    int          pulses;

    initial begin
        rst_n        = 1'b0;
        adc_clock    = 1'b0;
        dry_in       = '0;
        tap_valid    = 1'b0;
        tap_last     = 1'b0;
        impulse_word = '0;
        sample_word  = '0;
        tick();
        tick();
        check("rst_data_out", {16'd0, data_out}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_tap_ready", {31'd0, tap_ready}, 32'd0);
        check("rst_sat", {31'd0, sat_flag}, 32'd0);
        check("rst_overrun", {31'd0, overrun_flag}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single tap: (256*256 + 512*128) >>> 8 = 512; out_valid two cycles after tap
        start_frame(16'h0100);
        check("t1_busy", {31'd0, busy}, 32'd1);
        send_tap(16'h0200, 1'b0, 8'h80, 1'b1);
        check("t1_lat_n1", {31'd0, out_valid}, 32'd0);
        tick();
        check("t1_lat_n2", {31'd0, out_valid}, 32'd1);
        check("t1_data", {16'd0, data_out}, 32'h0200);
        tick();
        check("t1_pulse_end", {31'd0, out_valid}, 32'd0);
        check("t1_hold", {16'd0, data_out}, 32'h0200);
        check("t1_idle", {31'd0, busy}, 32'd0);
        check("t1_sat", {31'd0, sat_flag}, 32'd0);
        check("t1_overrun", {31'd0, overrun_flag}, 32'd0);

        // Negated tap cancels the dry sample; with dry=0 result is -256
        start_frame(16'h0100);
        send_tap(16'h0200, 1'b1, 8'h80, 1'b1);
        tick();
        check("t2_neg_data", {16'd0, data_out}, 32'h0000);
        tick();
        start_frame(16'h0000);
        send_tap(16'h0200, 1'b1, 8'h80, 1'b1);
        tick();
        check("t2_neg_only", {16'd0, data_out}, 32'hFF00);
        tick();

        // Positive saturation
        start_frame(16'h7000);
        for (int i = 0; i < 4; i++) send_tap(16'h7FFF, 1'b0, 8'hFF, (i == 3));
        tick();
        check("t3_data", {16'd0, data_out}, 32'h7FFF);
        check("t3_sat", {31'd0, sat_flag}, 32'd1);
        tick();

        // Reset mid-ACCUM discards the frame and clears sticky flags
        start_frame(16'h0100);
        send_tap(16'h0200, 1'b0, 8'h80, 1'b0);
        check("t6_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_data", {16'd0, data_out}, 32'd0);
        check("t6_sat", {31'd0, sat_flag}, 32'd0);
        check("t6_overrun", {31'd0, overrun_flag}, 32'd0);
        check("t6_busy_low", {31'd0, busy}, 32'd0);
        check("t6_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) pulses++;
        end
        check("t6_no_out", pulses, 32'd0);
        start_frame(16'h0100);
        send_tap(16'h0200, 1'b0, 8'h80, 1'b1);
        tick();
        check("t6_next_data", {16'd0, data_out}, 32'h0200);
        tick();

        // MAX_TAPS: exactly 255 taps consumed, 256th stalls; zero taps leave dry=5
        start_frame(16'h0005);
        sample_word  = 16'h0000;
        impulse_word = 16'h0000;
        tap_last     = 1'b0;
        tap_valid    = 1'b1;
        accepted     = 0;
        seen         = 1'b0;
        seen_data    = '0;
        for (int i = 0; i < 300; i++) begin
            if (tap_ready) accepted++;
            tick();
            if (out_valid) begin
                seen      = 1'b1;
                seen_data = data_out;
            end
        end
        check("t5_stall", {31'd0, tap_ready}, 32'd0);
        tap_valid = 1'b0;
        check("t5_accepted", accepted, 32'd255);
        check("t5_out_seen", {31'd0, seen}, 32'd1);
        check("t5_data", {16'd0, seen_data}, 32'h0005);
        check("t5_overrun", {31'd0, overrun_flag}, 32'd1);

        // Early frame edge after 3 taps: partial sum 3*128, then queued frame
        pulse_reset();
        check("t4_overrun_clr", {31'd0, overrun_flag}, 32'd0);
        start_frame(16'h0000);
        dry_in = 16'h0010;
        for (int i = 0; i < 3; i++) send_tap(16'h0100, 1'b0, 8'h80, 1'b0);
        tick();
        tick();
        tick();
        adc_clock = 1'b1;
        wait_out(d);
        check("t4_partial", {16'd0, d}, 32'h0180);
        check("t4_overrun", {31'd0, overrun_flag}, 32'd1);
        tick();
        check("t4_idle_gap", {31'd0, busy}, 32'd0);
        tick();
        check("t4_pending_start", {31'd0, tap_ready}, 32'd1);
        adc_clock = 1'b0;
        send_tap(16'h0100, 1'b0, 8'h80, 1'b1);
        tick();
        check("t4_second", {16'd0, data_out}, 32'h0090);
        tick();
        tick();
        tick();

        // Zero-tap frame: output is the dry sample itself
        start_frame(16'h8000);
        tick();
        tick();
        tick();
        adc_clock = 1'b1;
        wait_out(d);
        check("zt_data", {16'd0, d}, 32'h8000);
        check("zt_sat", {31'd0, sat_flag}, 32'd0);
        check("zt_overrun", {31'd0, overrun_flag}, 32'd1);
        adc_clock = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
